// File: rtl/shifter_pkg.sv
// Shared definitions for the shift datapath: default width, FSM state encoding
// and the one-hot validity check used by the shifters.
package shifter_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int MAX_WIDTH     = 64;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_SHIFT = SHIFT,
    ST_DONE  = DONE
  } state_t;

  // Narrower vectors are zero-extended by the caller; true when exactly one bit is set.
  function automatic logic is_onehot(input logic [MAX_WIDTH-1:0] v);
    return (v != '0) && ((v & (v - MAX_WIDTH'(1))) == '0);
  endfunction

endpackage

// File: rtl/onehot_to_bin.sv
// One-hot to binary index decoder with a flag that is high only when exactly
// one input bit is set.
module onehot_to_bin
  import shifter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] oh_i,
  output logic [CNT_W-1:0] idx_o,
  output logic             valid_o
);

  logic [MAX_WIDTH-1:0] oh_ext;

  always_comb begin
    oh_ext = '0;
    oh_ext[WIDTH-1:0] = oh_i;
  end

  // OR of the indices of all set bits; only meaningful when valid_o is high.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (oh_i[i]) idx_o = idx_o | CNT_W'(i);
    end
  end

  assign valid_o = is_onehot(oh_ext);

endmodule

// File: rtl/seq_rshifter.sv
// Iterative right shifter: one bit per clock, one-hot shift amount, done pulse.
// Define SEQ_RSHIFTER_ARITH_EN for arithmetic (sign-fill) shifts; default is logical.
module seq_rshifter
  import shifter_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] w,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] w_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  logic [CNT_W-1:0] k;
  logic             n_ok;
  logic             fill;
  logic [WIDTH-1:0] w_shift_d;

  onehot_to_bin #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_dec (
    .oh_i    (n),
    .idx_o   (k),
    .valid_o (n_ok)
  );

`ifdef SEQ_RSHIFTER_ARITH_EN
  assign fill = w_q[WIDTH-1];
`else
  assign fill = 1'b0;
`endif

  assign w_shift_d = {fill, w_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      w_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            err_q  <= ~n_ok;
            if (!n_ok) begin
              w_q     <= '0;
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else if (k == '0) begin
              w_q     <= d;
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              w_q     <= d;
              cnt_q   <= k;
              state_q <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          w_q   <= w_shift_d;
          cnt_q <= cnt_q - CNT_W'(1);
          // Last shift happens on this edge; done pulse follows it directly.
          if (cnt_q == CNT_W'(1)) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign w    = w_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_seq_rshifter.sv
// Directed bench for seq_rshifter; expected values are hand-computed and
// switch with SEQ_RSHIFTER_ARITH_EN to match the fill mode of the build.
module tb_seq_rshifter;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] d;
  logic [7:0] n;
  logic [7:0] w;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  seq_rshifter #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .d     (d),
    .n     (n),
    .w     (w),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one start, waits (bounded) for done; returns latency from the start
  // cycle, number of busy cycles and the cycle index of the done pulse.
  task automatic run_op(input string tag, input logic [7:0] dv, input logic [7:0] nv,
                        output int lat, output int bc, output int done_cyc);
    start = 1'b1;
    d     = dv;
    n     = nv;
    tick();
    start = 1'b0;
    d     = 8'($urandom);
    n     = 8'($urandom);
    lat   = 1;
    bc    = 0;
    while (!done && lat < 40) begin
      bc += int'(busy);
      tick();
      lat++;
    end
    bc += int'(busy);
    done_cyc = cyc;
    chk({tag, "_done_seen"}, done, 1'b1);
  endtask

  int lat, bc, dc1, dc2, dcount;
  logic [7:0] exp_w;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    d     = '0;
    n     = '0;
    tick();
    tick();
    chk("rst_w", w, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    rst = 1'b0;
    tick();

    // 1: 0x58 >> 3
    run_op("t1", 8'h58, 8'h08, lat, bc, dc1);
    chk("t1_lat", lat, 4);
    chk("t1_busy_cycles", bc, 4);
    chk("t1_w", w, 8'h0B);
    chk("t1_err", err, 1'b0);
    tick();
    chk("t1_done_one_cycle", done, 1'b0);
    chk("t1_busy_fall", busy, 1'b0);
    chk("t1_w_held", w, 8'h0B);

    // 2: fill-bit dependent cases
`ifdef SEQ_RSHIFTER_ARITH_EN
    exp_w = 8'hE4;
`else
    exp_w = 8'h24;
`endif
    run_op("t2a", 8'h90, 8'h04, lat, bc, dc1);
    chk("t2a_lat", lat, 3);
    chk("t2a_w", w, exp_w);
    tick();
`ifdef SEQ_RSHIFTER_ARITH_EN
    exp_w = 8'hFF;
`else
    exp_w = 8'h01;
`endif
    run_op("t2b", 8'hFF, 8'h80, lat, bc, dc1);
    chk("t2b_lat", lat, 8);
    chk("t2b_w", w, exp_w);
    tick();

    // 3: zero shift, invalid amounts, err clear
    run_op("t3a", 8'hA5, 8'h01, lat, bc, dc1);
    chk("t3a_lat", lat, 1);
    chk("t3a_w", w, 8'hA5);
    chk("t3a_err", err, 1'b0);
    tick();
    run_op("t3b", 8'hA5, 8'h00, lat, bc, dc1);
    chk("t3b_lat", lat, 1);
    chk("t3b_w", w, 8'h00);
    chk("t3b_err", err, 1'b1);
    tick();
    chk("t3b_err_held", err, 1'b1);
    run_op("t3c", 8'hA5, 8'h12, lat, bc, dc1);
    chk("t3c_lat", lat, 1);
    chk("t3c_w", w, 8'h00);
    chk("t3c_err", err, 1'b1);
    tick();
    run_op("t3d", 8'h3C, 8'h02, lat, bc, dc1);
    chk("t3d_w", w, 8'h1E);
    chk("t3d_err_cleared", err, 1'b0);
    tick();

    // 4: start while busy is ignored
    start = 1'b1;
    d     = 8'hFF;
    n     = 8'h40;
    tick();
    start = 1'b0;
    lat   = 1;
    tick();
    lat++;
    start = 1'b1;
    d     = 8'h00;
    n     = 8'h01;
    tick();
    lat++;
    start = 1'b0;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    chk("t4_done_seen", done, 1'b1);
    chk("t4_lat", lat, 7);
`ifdef SEQ_RSHIFTER_ARITH_EN
    exp_w = 8'hFF;
`else
    exp_w = 8'h03;
`endif
    chk("t4_w", w, exp_w);
    chk("t4_err", err, 1'b0);
    tick();
    chk("t4_not_queued_busy", busy, 1'b0);
    chk("t4_not_queued_done", done, 1'b0);

    // 5: reset mid-shift aborts
    start = 1'b1;
    d     = 8'hFF;
    n     = 8'h80;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("t5_busy_before_rst", busy, 1'b1);
    rst = 1'b1;
    tick();
    chk("t5_w", w, 8'h00);
    chk("t5_busy", busy, 1'b0);
    chk("t5_done", done, 1'b0);
    chk("t5_err", err, 1'b0);
    rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      dcount += int'(done) + int'(busy);
    end
    chk("t5_no_resume", dcount, 0);
    rst   = 1'b1;
    start = 1'b1;
    d     = 8'hFF;
    n     = 8'h01;
    tick();
    chk("t5_rst_beats_start_busy", busy, 1'b0);
    chk("t5_rst_beats_start_w", w, 8'h00);
    rst   = 1'b0;
    start = 1'b0;
    tick();
`ifdef SEQ_RSHIFTER_ARITH_EN
    exp_w = 8'hE0;
`else
    exp_w = 8'h20;
`endif
    run_op("t5b", 8'h81, 8'h04, lat, bc, dc1);
    chk("t5b_lat", lat, 3);
    chk("t5b_w", w, exp_w);
    tick();

    // 6: back-to-back, start in the cycle right after each done
`ifdef SEQ_RSHIFTER_ARITH_EN
    exp_w = 8'hC0;
`else
    exp_w = 8'h40;
`endif
    run_op("t6a", 8'h80, 8'h02, lat, bc, dc1);
    chk("t6a_w", w, exp_w);
    tick();
`ifdef SEQ_RSHIFTER_ARITH_EN
    exp_w = 8'hF8;
`else
    exp_w = 8'h08;
`endif
    run_op("t6b", 8'h80, 8'h10, lat, bc, dc2);
    chk("t6b_w", w, exp_w);
    chk("t6b_spacing", dc2 - dc1, 6);
    tick();
    chk("t6b_idle", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
